// File: rtl/fpa_seq_ctrl.sv
// fpa_seq_ctrl: multi-cycle single-precision adder sequencer (align, add, iterative normalise, truncating)
module fpa_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, big_q, big_d, result_q, result_d;
  logic [23:0] sig_big_q, sig_big_d, sig_sml_q, sig_sml_d;
  logic [22:0] sum_q, sum_d;
  logic [7:0] exp_q, exp_d;
  logic sub_q, sub_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic swap;
  logic [31:0] big_w, sml_w;
  logic [7:0] ediff, exp_inc;
  logic [24:0] add_sum;
  assign swap = b_q[30:0] > a_q[30:0];
  assign big_w = swap ? b_q : a_q;
  assign sml_w = swap ? a_q : b_q;
  assign ediff = big_w[30:23] - sml_w[30:23];
  assign add_sum = sub_q ? {1'b0, sig_big_q} - {1'b0, sig_sml_q} : {1'b0, sig_big_q} + {1'b0, sig_sml_q};
  assign exp_inc = big_q[30:23] + 8'd1;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    big_d = big_q;
    result_d = result_q;
    sig_big_d = sig_big_q;
    sig_sml_d = sig_sml_q;
    sum_d = sum_q;
    exp_d = exp_q;
    sub_d = sub_q;
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        a_d = a;
        b_d = b;
        state_d = ALIGN;
      end
      ALIGN: begin
        big_d = big_w;
        sub_d = big_w[31] ^ sml_w[31];
        sig_big_d = {|big_w[30:23], big_w[22:0]};
        sig_sml_d = ediff >= 8'd24 ? 24'd0 : {|sml_w[30:23], sml_w[22:0]} >> ediff;
        state_d = ADD;
      end
      ADD: begin
        sum_d = add_sum[22:0];
        exp_d = big_q[30:23];
        state_d = DONE;
        if (&big_q[30:23]) result_d = big_q;
        else if (add_sum == '0) result_d = '0;
        else if (add_sum[24]) result_d = &exp_inc ? {big_q[31], 8'hFF, 23'd0} : {big_q[31], exp_inc, add_sum[23:1]};
        else if (add_sum[23]) result_d = {big_q[31], big_q[30:23], add_sum[22:0]};
        else state_d = NORM;
      end
      NORM: begin
        sum_d = {sum_q[21:0], 1'b0};
        exp_d = exp_q - 8'd1;
        // Decrementing below exponent 1 cannot yield a normal number, so flush.
        if (exp_q <= 8'd1) begin
          result_d = '0;
          state_d = DONE;
        end else if (sum_q[22]) begin
          result_d = {big_q[31], exp_q - 8'd1, sum_q[21:0], 1'b0};
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      big_q <= '0;
      result_q <= '0;
      sig_big_q <= '0;
      sig_sml_q <= '0;
      sum_q <= '0;
      exp_q <= '0;
      sub_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      big_q <= big_d;
      result_q <= result_d;
      sig_big_q <= sig_big_d;
      sig_sml_q <= sig_sml_d;
      sum_q <= sum_d;
      exp_q <= exp_d;
      sub_q <= sub_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_fpa_seq_ctrl.sv
// tb_fpa_seq_ctrl: directed table, corner sequences and randomized ops against an arithmetic model
module tb_fpa_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [31:0] result;
  int pass_cnt = 0, total = 0;

  fpa_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int lat;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  // Spec rules with plain integer arithmetic; k counts NORM cycles, including a flushing one.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r, output int k);
    logic [31:0] big, sml;
    longint sb, ss, s;
    int eb, es, d, e;
    big = (y[30:0] > x[30:0]) ? y : x;
    sml = (y[30:0] > x[30:0]) ? x : y;
    eb = int'(big[30:23]);
    es = int'(sml[30:23]);
    sb = (eb != 0 ? 64'd8388608 : 64'd0) + longint'(big[22:0]);
    ss = (es != 0 ? 64'd8388608 : 64'd0) + longint'(sml[22:0]);
    d = eb - es;
    ss = d >= 24 ? 0 : ss / (64'd1 << d);
    s = big[31] == sml[31] ? sb + ss : sb - ss;
    k = 0;
    r = '0;
    if (eb == 255) r = big;
    else if (s == 0) r = '0;
    else if (s >= 64'd16777216) begin
      e = eb + 1;
      r = e == 255 ? {big[31], 8'hFF, 23'd0} : {big[31], 8'(e), 23'((s / 2) % 64'd8388608)};
    end else begin
      e = eb;
      while (s < 64'd8388608) begin
        k++;
        if (e <= 1) begin
          s = 0;
          break;
        end
        s = s * 2;
        e--;
      end
      r = s == 0 ? 32'd0 : {big[31], 8'(e), 23'(s % 64'd8388608)};
    end
  endfunction

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] er, input int elat, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", 32'(n < 50), 32'd1);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    out_ready = hold == 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 1;
    while (!out_valid && n < 40) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("result", result, er);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", result, er);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] er, ra, rb;
    int k, mode;
    vt[0] = '{32'h40C00000, 32'h41000000, 32'h41600000, 3};
    vt[1] = '{32'h411C0000, 32'h3F100000, 32'h41250000, 3};
    vt[2] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000, 3};
    vt[3] = '{32'h3F800000, 32'hBF700000, 32'h3D800000, 7};
    vt[4] = '{32'h40490FDB, 32'hC0490FDB, 32'h00000000, 3};
    vt[5] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 3};
    vt[6] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3};
    vt[7] = '{32'h00800000, 32'h80400000, 32'h00000000, 4};
    vt[8] = '{32'hC0000000, 32'h3F800000, 32'hBF800000, 4};
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].res, vt[i].lat, 0);
    run_op(32'h40490FDB, 32'hC0490FDB, 32'h00000000, 3, 5);
    run_op(32'h411C0000, 32'h3F100000, 32'h41250000, 3, 3);
    // reset during NORM of 1.0 + -0.9375
    a = 32'h3F800000;
    b = 32'hBF700000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("norm_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end
    run_op(32'h40C00000, 32'h41000000, 32'h41600000, 3, 0);
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      if (mode == 1) rb = {~ra[31], ra[30:0] ^ (rb & 32'h0000FFFF)};
      if (mode == 2) rb[30:23] = ra[30:23] + 8'($urandom_range(0, 2));
      if (mode == 3) begin
        ra[30:23] = 8'($urandom_range(0, 3));
        rb[30:23] = 8'($urandom_range(0, 3));
      end
      model(ra, rb, er, k);
      run_op(ra, rb, er, 3 + k, $urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : 0);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
